arm_phase_sequencer: RTL and testbench

Multicycle phase sequencer for the LEGv8 datapath. Replaces the fixed delayed-clock chain (clk+1…clk+6) with a single-clock FSM that issues one-cycle enables to fetch, decode/register-read, execute, data memory and register writeback. Computes the PC-select and PC-write strobes, waits on a data-memory ready handshake with timeout, and supports free-run and single-step execution. Sits in the datapath top beside `fetch`, `iDecode` and `iExecute`.

---
 rtl/arm_phase_sequencer_pkg.sv | 31 +++
 rtl/arm_phase_sequencer_if.sv | 34 +++
 rtl/arm_phase_sequencer_mem_wait_timer.sv | 31 +++
 rtl/arm_phase_sequencer.sv | 121 ++++++++++++
 tb/tb_arm_phase_sequencer.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/arm_phase_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// arm_seq_pkg
// Shared types for the LEGv8 multicycle phase sequencer.
//   seq_state_t     : FSM state encoding
//   dec_ctl_t       : decoder controls captured during DECODE
//   STATE_W         : state register width
//   DEF_MEM_TIMEOUT : default data-memory wait limit in MEM-state cycles
// ----------------------------------------------------------------------------
package arm_seq_pkg;

    localparam int STATE_W         = 3;
    localparam int DEF_MEM_TIMEOUT = 15;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_ERROR  = 3'd6
    } seq_state_t;

    typedef struct packed {
        logic is_mem;   // instruction visits MEM
        logic no_wb;    // instruction does not write the register file
        logic branch;
        logic uncond;
    } dec_ctl_t;

endpackage

// File: rtl/arm_phase_sequencer_if.sv
// ----------------------------------------------------------------------------
// arm_phase_sequencer_if
// Datapath-side signals of the phase sequencer.
//   master : the sequencer (takes decoder/ALU/memory status, drives enables)
//   slave  : the datapath (drives status, takes enables and PC strobes)
// Status : mem_read, mem_write, branch, uncond_branch, zero, mem_ready
// Enables: fetch_en, decode_en, exec_en, mem_en, wb_en, pc_src, pc_we
// ----------------------------------------------------------------------------
interface arm_phase_sequencer_if;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic uncond_branch;
    logic zero;
    logic mem_ready;

    logic fetch_en;
    logic decode_en;
    logic exec_en;
    logic mem_en;
    logic wb_en;
    logic pc_src;
    logic pc_we;

    modport master (
        input  mem_read, mem_write, branch, uncond_branch, zero, mem_ready,
        output fetch_en, decode_en, exec_en, mem_en, wb_en, pc_src, pc_we
    );

    modport slave (
        output mem_read, mem_write, branch, uncond_branch, zero, mem_ready,
        input  fetch_en, decode_en, exec_en, mem_en, wb_en, pc_src, pc_we
    );
endinterface

// File: rtl/arm_phase_sequencer_mem_wait_timer.sv
// ----------------------------------------------------------------------------
// mem_wait_timer
// Counts MEM-state cycles spent without mem_ready.
//   clk, reset : clock, synchronous active-low reset
//   clr        : restart count at zero (sequencer outside MEM)
//   en         : count this cycle (in MEM, ready not seen)
//   expired    : this counted cycle brings the count to MEM_TIMEOUT
// ----------------------------------------------------------------------------
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset || clr) cnt <= '0;
        else if (en)       cnt <= cnt + CW'(1);
    end

    // Flagged on the cycle that would make the count reach MEM_TIMEOUT, so the
    // FSM leaves for ERROR on the same edge instead of spending an extra cycle.
    assign expired = en && (cnt == CW'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/arm_phase_sequencer.sv
// ----------------------------------------------------------------------------
// arm_phase_sequencer
// Single-clock multicycle phase sequencer for the LEGv8 datapath. Issues
// one-cycle phase enables (FETCH, DECODE, EXEC, MEM, WB), PC strobes, and
// waits on data memory with a timeout that parks the FSM in ERROR.
//   clk, reset  : clock, synchronous active-low reset
//   run         : free-run level
//   step        : single-instruction pulse, honoured only in IDLE
//   dp          : datapath interface (master side)
//   busy        : in FETCH..WB
//   mem_error   : sticky memory timeout flag
//   cycle_count, instr_count : perf counters, only with ARM_SEQ_PERF_EN
// All outputs are registered from the next-state decode, so an enable is high
// exactly during the cycle its state is current and no input reaches an
// output combinationally.
// ----------------------------------------------------------------------------
module arm_phase_sequencer
    import arm_seq_pkg::*;
#(
    parameter int WORD        = 64,
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    input  logic                  step,
    arm_phase_sequencer_if.master dp,
    output logic                  busy,
    output logic                  mem_error
`ifdef ARM_SEQ_PERF_EN
    ,
    output logic [WORD-1:0]       cycle_count,
    output logic [WORD-1:0]       instr_count
`endif
);

    seq_state_t state, state_nxt;
    dec_ctl_t   ctl_q, ctl_nxt;
    logic       pc_src_q, pc_src_nxt;
    logic       tmr_expired;

    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (state != S_MEM),
        .en      ((state == S_MEM) && !dp.mem_ready),
        .expired (tmr_expired)
    );

    always_comb begin
        state_nxt  = state;
        ctl_nxt    = ctl_q;
        pc_src_nxt = pc_src_q;
        case (state)
            S_IDLE:   if (run || step) state_nxt = S_FETCH;
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: begin
                state_nxt      = S_EXEC;
                ctl_nxt.is_mem = dp.mem_read | dp.mem_write;
                ctl_nxt.no_wb  = dp.mem_write | dp.branch | dp.uncond_branch;
                ctl_nxt.branch = dp.branch;
                ctl_nxt.uncond = dp.uncond_branch;
            end
            S_EXEC: begin
                pc_src_nxt = ctl_q.uncond | (ctl_q.branch & dp.zero);
                state_nxt  = ctl_q.is_mem ? S_MEM : S_WB;
            end
            S_MEM: begin
                // Ready wins over expiry on the last allowed cycle.
                if (dp.mem_ready)     state_nxt = S_WB;
                else if (tmr_expired) state_nxt = S_ERROR;
            end
            S_WB:     state_nxt = run ? S_FETCH : S_IDLE;
            S_ERROR:  state_nxt = S_ERROR;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= S_IDLE;
            ctl_q        <= '0;
            pc_src_q     <= 1'b0;
            dp.fetch_en  <= 1'b0;
            dp.decode_en <= 1'b0;
            dp.exec_en   <= 1'b0;
            dp.mem_en    <= 1'b0;
            dp.wb_en     <= 1'b0;
            dp.pc_we     <= 1'b0;
            dp.pc_src    <= 1'b0;
            busy         <= 1'b0;
            mem_error    <= 1'b0;
        end else begin
            state        <= state_nxt;
            ctl_q        <= ctl_nxt;
            pc_src_q     <= pc_src_nxt;
            dp.fetch_en  <= (state_nxt == S_FETCH);
            dp.decode_en <= (state_nxt == S_DECODE);
            dp.exec_en   <= (state_nxt == S_EXEC);
            dp.mem_en    <= (state_nxt == S_MEM);
            dp.wb_en     <= (state_nxt == S_WB) && !ctl_nxt.no_wb;
            dp.pc_we     <= (state_nxt == S_WB);
            dp.pc_src    <= (state_nxt == S_WB) && pc_src_nxt;
            busy         <= (state_nxt != S_IDLE) && (state_nxt != S_ERROR);
            mem_error    <= mem_error || (state_nxt == S_ERROR);
        end
    end

`ifdef ARM_SEQ_PERF_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            cycle_count <= '0;
            instr_count <= '0;
        end else begin
            if (busy)          cycle_count <= cycle_count + WORD'(1);
            if (state == S_WB) instr_count <= instr_count + WORD'(1);
        end
    end
`endif

endmodule

// File: tb/tb_arm_phase_sequencer.sv
// ----------------------------------------------------------------------------
// tb_arm_phase_sequencer
// Directed bench for arm_phase_sequencer. Inputs change 1 ns after a rising
// edge; outputs are observed at the same point. obs packs
// {fetch, decode, exec, mem, wb, pc_we, pc_src, busy, mem_error}.
// Perf counter checks are compiled in with ARM_SEQ_PERF_EN.
// ----------------------------------------------------------------------------
module tb_arm_phase_sequencer;

    logic clk = 1'b0;
    logic reset, run, step, busy, mem_error;
`ifdef ARM_SEQ_PERF_EN
    logic [63:0] cycle_count, instr_count;
`endif

    arm_phase_sequencer_if dp_if ();

    arm_phase_sequencer #(.WORD(64), .MEM_TIMEOUT(15)) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .step       (step),
        .dp         (dp_if),
        .busy       (busy),
        .mem_error  (mem_error)
`ifdef ARM_SEQ_PERF_EN
        ,
        .cycle_count(cycle_count),
        .instr_count(instr_count)
`endif
    );

    always #5 clk = ~clk;

    // Expected observation patterns
    localparam logic [8:0] O_IDLE = 9'b000000000;
    localparam logic [8:0] O_F    = 9'b100000010;
    localparam logic [8:0] O_D    = 9'b010000010;
    localparam logic [8:0] O_E    = 9'b001000010;
    localparam logic [8:0] O_M    = 9'b000100010;
    localparam logic [8:0] O_WB   = 9'b000011010; // wb, pc_we, pc_src=0
    localparam logic [8:0] O_BT   = 9'b000001110; // no wb, pc_we, pc_src=1
    localparam logic [8:0] O_BN   = 9'b000001010; // no wb, pc_we, pc_src=0
    localparam logic [8:0] O_ERR  = 9'b000000001;

    logic [8:0] obs;
    assign obs = {dp_if.fetch_en, dp_if.decode_en, dp_if.exec_en, dp_if.mem_en,
                  dp_if.wb_en, dp_if.pc_we, dp_if.pc_src, busy, mem_error};

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input string tag, input logic [8:0] exp);
        tick();
        chk(tag, {55'd0, obs}, {55'd0, exp});
    endtask

    task automatic set_ctl(input logic mr, input logic mw, input logic br,
                           input logic ub, input logic z);
        dp_if.mem_read      = mr;
        dp_if.mem_write     = mw;
        dp_if.branch        = br;
        dp_if.uncond_branch = ub;
        dp_if.zero          = z;
    endtask

    initial begin
        reset = 1'b0; run = 1'b0; step = 1'b0;
        set_ctl(0, 0, 0, 0, 0);
        dp_if.mem_ready = 1'b0;
        tick(); tick();
        chk("reset_state", {55'd0, obs}, {55'd0, O_IDLE});

        // ADD under run, back-to-back into LDUR
        reset = 1'b1; run = 1'b1;
        cyc("add_f", O_F); cyc("add_d", O_D); cyc("add_e", O_E); cyc("add_wb", O_WB);

        // LDUR, ready after 3 wait cycles: WB in cycle 8 of the instruction
        set_ctl(1, 0, 0, 0, 0);
        cyc("ldr_f_no_bubble", O_F); cyc("ldr_d", O_D); cyc("ldr_e", O_E);
        cyc("ldr_m0", O_M); cyc("ldr_m1", O_M); cyc("ldr_m2", O_M); cyc("ldr_m3", O_M);
        dp_if.mem_ready = 1'b1;
        cyc("ldr_wb", O_WB);
        dp_if.mem_ready = 1'b0;

        // CBZ taken / not taken
        set_ctl(0, 0, 1, 0, 1);
        cyc("cbz1_f", O_F); cyc("cbz1_d", O_D); cyc("cbz1_e", O_E); cyc("cbz1_wb", O_BT);
        set_ctl(0, 0, 1, 0, 0);
        cyc("cbz0_f", O_F); cyc("cbz0_d", O_D); cyc("cbz0_e", O_E); cyc("cbz0_wb", O_BN);

        // B, run dropped mid-instruction: completes then IDLE
        set_ctl(0, 0, 0, 1, 0);
        cyc("b_f", O_F); cyc("b_d", O_D);
        run = 1'b0;
        cyc("b_e", O_E); cyc("b_wb", O_BT); cyc("b_idle", O_IDLE);

        // Single step; second step during busy ignored
        set_ctl(0, 0, 0, 0, 0);
        step = 1'b1;
        cyc("step_f", O_F);
        cyc("step_d", O_D);          // step still high in FETCH: ignored
        step = 1'b0;
        cyc("step_e", O_E); cyc("step_wb", O_WB);
        cyc("step_idle", O_IDLE); cyc("step_idle_hold", O_IDLE);

        // Reset during EXEC: no WB, no PC write
        step = 1'b1;
        cyc("rst_f", O_F);
        step = 1'b0;
        cyc("rst_d", O_D); cyc("rst_e", O_E);
        reset = 1'b0;
        cyc("rst_mid_exec", O_IDLE);
        reset = 1'b1;
        cyc("rst_after", O_IDLE);

        // LDUR with ready on the last allowed MEM cycle (index 14)
        set_ctl(1, 0, 0, 0, 0);
        step = 1'b1;
        cyc("late_f", O_F);
        step = 1'b0;
        cyc("late_d", O_D); cyc("late_e", O_E);
        for (int i = 0; i < 15; i++) cyc($sformatf("late_m%0d", i), O_M);
        dp_if.mem_ready = 1'b1;
        cyc("late_wb", O_WB);
        dp_if.mem_ready = 1'b0;
        cyc("late_idle", O_IDLE);

        // STUR, ready never: 15 MEM cycles then ERROR, held until reset
        set_ctl(0, 1, 0, 0, 0);
        step = 1'b1;
        cyc("to_f", O_F);
        step = 1'b0;
        cyc("to_d", O_D); cyc("to_e", O_E);
        for (int i = 0; i < 15; i++) cyc($sformatf("to_m%0d", i), O_M);
        cyc("to_error", O_ERR);
        step = 1'b1; run = 1'b1;
        cyc("to_error_hold", O_ERR);
        step = 1'b0;
        cyc("to_error_hold2", O_ERR);
        run = 1'b0; reset = 1'b0;
        cyc("to_reset_clears", O_IDLE);
        reset = 1'b1;
        set_ctl(0, 0, 0, 0, 0);

`ifdef ARM_SEQ_PERF_EN
        // 3 ADDs under run: 12 busy cycles, 3 WB exits
        reset = 1'b0;
        tick();
        chk("perf_rst_cycles", cycle_count, 64'd0);
        chk("perf_rst_instrs", instr_count, 64'd0);
        reset = 1'b1; run = 1'b1;
        repeat (11) tick();
        run = 1'b0;
        tick(); tick();
        chk("perf_idle", {55'd0, obs}, {55'd0, O_IDLE});
        chk("perf_cycles", cycle_count, 64'd12);
        chk("perf_instrs", instr_count, 64'd3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
